pc_unit: RTL
============

# pc_unit

Parametrised program-counter unit for the mono-cycle core. It replaces the bare PC register with a block that owns next-PC selection: sequential step, branch, jump, return, trap entry and trap return. It adds stall hold, target-alignment checking, a saved exception PC, and a small circular return-address stack (RAS). It sits between the control unit / ALU branch logic and the instruction memory address port.

## Interface

Parameters:
- WIDTH, 32, PC and target width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0080, PC value loaded on trap entry.
- STEP, 4, sequential increment in bytes.
- RAS_DEPTH, 4, number of return-address entries (power of two, ≥2).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC; blocks all redirects except trap.
- branch_taken  in  1  conditional branch resolved taken.
- branch_target  in  WIDTH  branch destination.
- jump_valid  in  1  unconditional jump (JAL/JALR).
- jump_target  in  WIDTH  jump destination.
- call  in  1  qualifies jump_valid; pushes pc+STEP onto the RAS.
- ret  in  1  return; redirect to the RAS top, or to jump_target if the RAS is empty.
- trap  in  1  exception request.
- mret  in  1  return from trap to epc.
- pc  out  WIDTH  current PC (registered).
- pc_plus_step  out  WIDTH  pc+STEP (combinational).
- epc  out  WIDTH  saved exception PC (registered).
- misaligned  out  1  combinational: the selected redirect target has target[1:0]≠0.
- ras_empty  out  1  RAS count == 0.
- ras_full  out  1  RAS count == RAS_DEPTH.
- ras_overflow  out  1  sticky: a push occurred while full. Cleared only by reset.

## Operation

Reset (reset_n low, asynchronous):
- pc=RESET_VECTOR
- epc=0
- RAS count=0, RAS pointer=0
- ras_overflow=0
- RAS entry contents don't-care.

Next-PC priority, highest first (evaluated each cycle):
1. **trap**: pc←TRAP_VECTOR, epc←pc. Takes effect even while stall=1.
2. **Misaligned redirect** (rows 4–7 below selected and misaligned=1): treated as a trap. pc←TRAP_VECTOR, epc←pc. The RAS is not modified.
3. **stall**: pc, epc and RAS all hold.
4. **mret**: pc←epc.
5. **ret**: if ras_empty=0, pc←RAS top and pop. If empty, pc←jump_target and count stays 0.
6. **jump_valid**: pc←jump_target. If call=1, push pc+STEP.
7. **branch_taken**: pc←branch_target.
8. **Otherwise**: pc←pc+STEP.

Arithmetic:
- pc+STEP wraps modulo 2^WIDTH; there is no carry out.

RAS behaviour:
- Push while full: overwrites the oldest entry (circular), count stays RAS_DEPTH, ras_overflow←1.
- ret with jump_valid&call in the same cycle (co-routine swap): the pop and push combine. The top entry is replaced with pc+STEP, count is unchanged, and pc←old top. If the RAS was empty, pc←jump_target and the push proceeds normally (count becomes 1).
- call without jump_valid: ignored.
- Any row-1/row-2 trap cycle leaves the RAS untouched.

Alignment checking:
- Applies to mret targets, RAS top, jump_target and branch_target (only the selected one).
- Sequential stepping is never checked.

## Timing

- Single-cycle: the selection made from inputs in cycle N is visible on pc after rising edge N+1.
- No handshake. All inputs are sampled only at rising edges. Inputs must be stable at the setup point.
- Outputs:
  - pc_plus_step and misaligned are combinational from pc and the inputs.
  - All other outputs are registered.
  - ras_empty and ras_full are decoded from the registered count.
- Reset asserted mid-cycle forces outputs to their reset values immediately, without waiting for a clock edge.
- Release of reset_n is synchronous to the next rising edge. The first fetch address is RESET_VECTOR.

## Test plan

1. **Reset and stepping:** reset_n low, then release. Apply 3 clocks with all requests 0. Expect pc = 0x0, 0x4, 0x8, 0xC. Assert reset_n mid-run: expect pc=0x0 immediately.
2. **Priority and stall:** at pc=0x10, assert branch_taken (target 0x40) and jump_valid (target 0x80) together. Expect pc=0x80. Then hold stall=1 with branch_taken for 2 cycles: expect pc held. Then assert trap while stall=1: expect pc=0x80 vector and epc=held pc.
3. **Call/return:** at pc=0x100, jump_valid+call to 0x200. Expect pc=0x200, ras_empty=0. Step to 0x204, then ret: expect pc=0x104, ras_empty=1. Apply ret with RAS empty and jump_target=0x300: expect pc=0x300.
4. **RAS overflow and wrap:** with RAS_DEPTH=4, perform 5 calls from pcs 0x0, 0x10, 0x20, 0x30, 0x40. Expect ras_full=1, ras_overflow=1. Four rets then return 0x44, 0x34, 0x24, 0x14 and ras_empty=1. ras_overflow stays 1.
5. **Misalignment:** at pc=0x50, branch_taken with target 0x62. Expect misaligned=1 that cycle, then pc=TRAP_VECTOR and epc=0x50. Then mret: expect pc=0x50.
6. **Wrap-around:** force pc=0xFFFF_FFFC via jump, then step one cycle. Expect pc=0x0000_0000.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: program-counter unit owning next-PC selection (step, branch,
// jump, return, trap entry/return), stall hold, target alignment checking,
// a saved exception PC and a small circular return-address stack.
module pc_unit #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h0000_0080),
    parameter int               STEP         = 4,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump_valid,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             call,
    input  logic             ret,
    input  logic             trap,
    input  logic             mret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus_step,
    output logic [WIDTH-1:0] epc,
    output logic             misaligned,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_overflow
);

    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    ptr_q, ptr_d;      // next free slot; top is ptr_q-1
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];

    logic [PW-1:0]    top_idx;
    logic [WIDTH-1:0] ras_top;
    logic             redirect;
    logic [WIDTH-1:0] target;
    logic             want_push, want_pop, want_swap;
    logic             take_trap;
    logic             ras_we;
    logic [PW-1:0]    ras_waddr;

    assign pc_plus_step = pc_q + WIDTH'(STEP);
    assign pc           = pc_q;
    assign epc          = epc_q;
    assign ras_empty    = (count_q == '0);
    assign ras_full     = (count_q == CW'(RAS_DEPTH));
    assign ras_overflow = ovf_q;
    assign top_idx      = ptr_q - PW'(1);
    assign ras_top      = ras_q[top_idx];

    // Pick the redirect target (rows mret..branch) and the RAS action it implies.
    always_comb begin
        redirect  = 1'b0;
        target    = '0;
        want_push = 1'b0;
        want_pop  = 1'b0;
        want_swap = 1'b0;
        if (mret) begin
            redirect = 1'b1;
            target   = epc_q;
        end else if (ret) begin
            redirect = 1'b1;
            if (!ras_empty) begin
                target = ras_top;
                // A call in the same cycle turns the pop+push into a swap of the top.
                if (jump_valid && call) want_swap = 1'b1;
                else                    want_pop  = 1'b1;
            end else begin
                target    = jump_target;
                want_push = jump_valid && call;
            end
        end else if (jump_valid) begin
            redirect  = 1'b1;
            target    = jump_target;
            want_push = call;
        end else if (branch_taken) begin
            redirect = 1'b1;
            target   = branch_target;
        end
        // A stalled cycle selects no redirect, so nothing can be misaligned.
        misaligned = !stall && redirect && (target[1:0] != 2'b00);
        take_trap  = trap || misaligned;
    end

    // Next-state for pc, epc and the RAS bookkeeping, trap first, then stall.
    always_comb begin
        pc_d      = pc_q;
        epc_d     = epc_q;
        count_d   = count_q;
        ptr_d     = ptr_q;
        ovf_d     = ovf_q;
        ras_we    = 1'b0;
        ras_waddr = ptr_q;
        if (take_trap) begin
            pc_d  = TRAP_VECTOR;
            epc_d = pc_q;
        end else if (!stall) begin
            pc_d = redirect ? target : pc_plus_step;
            if (want_swap) begin
                ras_we    = 1'b1;
                ras_waddr = top_idx;
            end else if (want_push) begin
                // When full, ptr_q already points at the oldest entry.
                ras_we    = 1'b1;
                ras_waddr = ptr_q;
                ptr_d     = ptr_q + PW'(1);
                if (ras_full) ovf_d   = 1'b1;
                else          count_d = count_q + CW'(1);
            end else if (want_pop) begin
                ptr_d   = top_idx;
                count_d = count_q - CW'(1);
            end
        end
    end

    // Architectural state with asynchronous reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
            count_q <= '0;
            ptr_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            count_q <= count_d;
            ptr_q   <= ptr_d;
            ovf_q   <= ovf_d;
        end
    end

    // RAS storage; contents are don't-care after reset so no reset here.
    always_ff @(posedge clock) begin
        if (ras_we) ras_q[ras_waddr] <= pc_plus_step;
    end

endmodule
